// File: rtl/cache_pkg.sv
// Shared definitions for the cache memory-side responder: block geometry
// defaults and the responder FSM state encoding.
package cache_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK;
  localparam int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELEASE
  } mem_state_t;

endpackage

// File: rtl/mem_block_array.sv
// Single-port block storage: synchronous write, registered read.
// The read register holds its value until the next read, so it can drive
// the refill data bus directly.
module mem_block_array #(
  parameter int MEM_BLOCKS = 1024,
  parameter int BLOCK_SIZE = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(MEM_BLOCKS)-1:0] addr,
  input  logic                          we,
  input  logic [BLOCK_SIZE-1:0]         wr_data,
  input  logic                          re,
  output logic [BLOCK_SIZE-1:0]         rd_data
);

  // Backing store; left public by name so benches can preload it.
  logic [BLOCK_SIZE-1:0] mem [MEM_BLOCKS];

  // Commit a block write.
  // NOTE: the storage array has no reset on purpose -- its contents must
  // survive rst_n, and a reset would prevent mapping it onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  // Registered read port; clears on reset and holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache refill/write-back interface.
// Accepts one request at a time, waits a fixed latency, then completes it
// with a one-cycle mem_ready pulse. Enables are levels held by the cache;
// the RELEASE state waits for them to drop so a held enable cannot
// retrigger a second transaction.
module cache_mem_responder #(
  parameter int WORD_SIZE       = cache_pkg::WORD_SIZE,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
  parameter int MEM_BLOCKS      = 1024,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 3,
  parameter int BADDR_WIDTH     = 32 - $clog2(WORDS_PER_BLOCK)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BADDR_WIDTH-1:0] blk_addr,
  input  logic                   read_en_mem,
  input  logic                   write_en_mem,
  input  logic [BLOCK_SIZE-1:0]  dirty_block_out,
  output logic [BLOCK_SIZE-1:0]  data_in_mem,
  output logic                   mem_ready,
  output logic                   busy
);

  import cache_pkg::*;

  localparam int IDX_W   = $clog2(MEM_BLOCKS);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  mem_state_t            state;
  logic [CNT_W-1:0]      counter;
  logic [IDX_W-1:0]      latched_idx;
  logic [BLOCK_SIZE-1:0] latched_data;

  logic array_we;
  logic array_re;

  // Upper address bits alias onto the same storage block by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^blk_addr[BADDR_WIDTH-1:IDX_W];

  // Array access happens on the edge where the wait counter has expired,
  // the same edge that raises mem_ready.
  assign array_re = (state == READ_WAIT)  && (counter == '0);
  assign array_we = (state == WRITE_WAIT) && (counter == '0);
  assign busy     = (state != IDLE);

  // Request acceptance, latency countdown and completion handshake.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counter      <= '0;
      mem_ready    <= 1'b0;
      latched_idx  <= '0;
      latched_data <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Write-back goes first so a refill of the same block sees it.
          if (write_en_mem) begin
            latched_idx  <= blk_addr[IDX_W-1:0];
            latched_data <= dirty_block_out;
            counter      <= CNT_W'(WRITE_LATENCY - 1);
            state        <= WRITE_WAIT;
          end else if (read_en_mem) begin
            latched_idx <= blk_addr[IDX_W-1:0];
            counter     <= CNT_W'(READ_LATENCY - 1);
            state       <= READ_WAIT;
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          // Committed once accepted: enables are not looked at here.
          if (counter == '0) begin
            mem_ready <= 1'b1;
            state     <= RELEASE;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!read_en_mem && !write_en_mem) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_block_array #(
    .MEM_BLOCKS (MEM_BLOCKS),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (latched_idx),
    .we      (array_we),
    .wr_data (latched_data),
    .re      (array_re),
    .rd_data (data_in_mem)
  );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: default build (read 4 / write 3)
// plus a READ_LATENCY=1 build. Expected completions are queued when a
// request is driven and compared when mem_ready is seen.
module tb_cache_mem_responder;

  localparam int BS = 128;
  localparam int AW = 30;

  typedef struct {
    int          lat;
    logic [BS-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] blk_addr;
  logic          read_en_mem;
  logic          write_en_mem;
  logic [BS-1:0] dirty_block_out;
  logic [BS-1:0] data_in_mem;
  logic          mem_ready;
  logic          busy;

  logic [AW-1:0] r1_addr;
  logic          r1_re;
  logic          r1_we;
  logic [BS-1:0] r1_wdata;
  logic [BS-1:0] r1_data;
  logic          r1_ready;
  logic          r1_busy;

  int errors = 0;
  int checks = 0;

  exp_t          sb [$];
  logic [BS-1:0] model [int];
  logic [BS-1:0] last_rd;

  cache_mem_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .blk_addr        (blk_addr),
    .read_en_mem     (read_en_mem),
    .write_en_mem    (write_en_mem),
    .dirty_block_out (dirty_block_out),
    .data_in_mem     (data_in_mem),
    .mem_ready       (mem_ready),
    .busy            (busy)
  );

  cache_mem_responder #(.READ_LATENCY(1)) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .blk_addr        (r1_addr),
    .read_en_mem     (r1_re),
    .write_en_mem    (r1_we),
    .dirty_block_out (r1_wdata),
    .data_in_mem     (r1_data),
    .mem_ready       (r1_ready),
    .busy            (r1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [BS-1:0] d);
    dut.u_array.mem[idx] = d;
    model[idx] = d;
  endtask

  // Drive one request (called just after a rising edge), follow it through
  // completion and release, comparing against the queued expectation.
  task automatic do_req(input bit wr, input bit rd, input logic [AW-1:0] a,
                        input logic [BS-1:0] d, input bit drop_early, input string tag);
    exp_t e;
    int   k;
    int   idx;
    idx   = int'(a[9:0]);
    e.lat = wr ? 3 : 4;
    if (wr) begin
      e.data     = last_rd;
      model[idx] = d;
    end else begin
      e.data  = model.exists(idx) ? model[idx] : '0;
      last_rd = e.data;
    end
    sb.push_back(e);
    write_en_mem    = wr;
    read_en_mem     = rd;
    blk_addr        = a;
    dirty_block_out = d;
    @(posedge clk); #1;
    check({tag, " accept busy"}, BS'(busy), BS'(1));
    if (drop_early) begin
      write_en_mem = 1'b0;
      read_en_mem  = 1'b0;
    end
    k = 0;
    while (k < 20 && !mem_ready) begin
      @(posedge clk); #1;
      k++;
    end
    e = sb.pop_front();
    check({tag, " latency"}, BS'(k), BS'(e.lat));
    check({tag, " data"}, data_in_mem, e.data);
    check({tag, " busy at ready"}, BS'(busy), BS'(1));
    if (!drop_early) begin
      repeat (2) begin
        @(posedge clk); #1;
        check({tag, " held release"}, BS'({mem_ready, busy}), BS'(2'b01));
      end
    end
    write_en_mem = 1'b0;
    read_en_mem  = 1'b0;
    @(posedge clk); #1;
    check({tag, " back to idle"}, BS'({mem_ready, busy}), BS'(2'b00));
  endtask

  // Read on the READ_LATENCY=1 instance: ready on the edge after acceptance.
  task automatic do_req1(input logic [AW-1:0] a, input logic [BS-1:0] exp_d, input string tag);
    exp_t e;
    int   k;
    e.lat  = 1;
    e.data = exp_d;
    sb.push_back(e);
    r1_addr = a;
    r1_re   = 1'b1;
    @(posedge clk); #1;
    check({tag, " accept busy"}, BS'(r1_busy), BS'(1));
    k = 0;
    while (k < 20 && !r1_ready) begin
      @(posedge clk); #1;
      k++;
    end
    e = sb.pop_front();
    check({tag, " latency"}, BS'(k), BS'(e.lat));
    check({tag, " data"}, r1_data, e.data);
    @(posedge clk); #1;
    check({tag, " held release"}, BS'({r1_ready, r1_busy}), BS'(2'b01));
    r1_re = 1'b0;
    @(posedge clk); #1;
    check({tag, " back to idle"}, BS'({r1_ready, r1_busy}), BS'(2'b00));
  endtask

  initial begin
    logic [BS-1:0] d5;
    logic [BS-1:0] dw;
    logic [BS-1:0] d7;
    logic [BS-1:0] d9;
    d5 = 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321;
    dw = 128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333;
    d7 = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;
    d9 = 128'h11111111_11111111_11111111_11111111;

    rst_n           = 1'b0;
    blk_addr        = '0;
    read_en_mem     = 1'b0;
    write_en_mem    = 1'b0;
    dirty_block_out = '0;
    r1_addr         = '0;
    r1_re           = 1'b0;
    r1_we           = 1'b0;
    r1_wdata        = '0;
    last_rd         = '0;

    preload(5, d5);
    preload(9, d9);
    u_dut1.u_array.mem[3] = 128'h33333333_44444444_55555555_66666666;
    u_dut1.u_array.mem[4] = 128'h77777777_88888888_99999999_AAAAAAAA;

    #1;
    check("reset busy", BS'(busy), BS'(0));
    check("reset mem_ready", BS'(mem_ready), BS'(0));
    check("reset data", data_in_mem, '0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Refill of a preloaded block with the enable held past completion.
    do_req(1'b0, 1'b1, 30'd5, '0, 1'b0, "read5");

    // Write-back, then refill of the same aliased address.
    do_req(1'b1, 1'b0, 30'h1ABCDE0, dw, 1'b0, "write_far");
    check("write keeps refill data", data_in_mem, d5);
    do_req(1'b0, 1'b1, 30'h1ABCDE0, '0, 1'b0, "read_far");

    // Both enables in IDLE: the write wins, then a read sees it.
    do_req(1'b1, 1'b1, 30'd7, d7, 1'b0, "both7");
    do_req(1'b0, 1'b1, 30'd7, '0, 1'b0, "read7");

    // Enables dropped right after acceptance still complete on time.
    do_req(1'b0, 1'b1, 30'd5, '0, 1'b1, "read5_drop");
    do_req(1'b1, 1'b0, 30'd12, dw, 1'b1, "write12_drop");

    // Reset during WRITE_WAIT discards the write.
    write_en_mem    = 1'b1;
    blk_addr        = 30'd9;
    dirty_block_out = dw;
    @(posedge clk); #1;
    check("rstmid accept busy", BS'(busy), BS'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstmid busy", BS'(busy), BS'(0));
    check("rstmid mem_ready", BS'(mem_ready), BS'(0));
    check("rstmid data", data_in_mem, '0);
    write_en_mem = 1'b0;
    last_rd      = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 1'b1, 30'd9, '0, 1'b0, "read9_after_rst");

    // READ_LATENCY=1 build, two reads separated by one idle-enable cycle.
    do_req1(30'd3, 128'h33333333_44444444_55555555_66666666, "lat1_read3");
    do_req1(30'd4, 128'h77777777_88888888_99999999_AAAAAAAA, "lat1_read4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Main-memory responder on the memory side of the set-associative cache's refill/write-back interface.
- Accepts block refill requests (read_en_mem) and dirty-victim write-backs (write_en_mem with dirty_block_out) from the cache controller.
- Models a fixed, parameterised access latency and returns whole blocks on data_in_mem.
- Replaces the hand-driven memory stimulus in cache benches; serves as a synthesizable backing-store model.

Parameters:
- WORD_SIZE, 32, bits per word
- WORDS_PER_BLOCK, 4, words per cache block
- BLOCK_SIZE, WORD_SIZE*WORDS_PER_BLOCK, bits per block
- MEM_BLOCKS, 1024, number of blocks stored (power of two)
- READ_LATENCY, 4, cycles from request acceptance to mem_ready for reads (>=1)
- WRITE_LATENCY, 3, cycles from request acceptance to mem_ready for writes (>=1)
- BADDR_WIDTH, 32-$clog2(WORDS_PER_BLOCK), block address width ({tag,index})

Ports:
- clk, input, 1, single clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- blk_addr, input, BADDR_WIDTH, block address {tag,index}; sampled on acceptance
- read_en_mem, input, 1, refill request; level, held until mem_ready
- write_en_mem, input, 1, write-back request; level, held until mem_ready
- dirty_block_out, input, BLOCK_SIZE, write-back data; sampled on acceptance
- data_in_mem, output, BLOCK_SIZE, refill data; valid while mem_ready=1
- mem_ready, output, 1, one-cycle completion pulse
- busy, output, 1, high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-deassert is the integrator's concern): state=IDLE, counter=0, mem_ready=0, busy=0, data_in_mem=0. Storage array is not cleared; its contents survive reset.
- Storage index = blk_addr[$clog2(MEM_BLOCKS)-1:0]; upper address bits are ignored (aliasing is intended).
- IDLE:
  - write_en_mem=1: latch addr and data, load counter=WRITE_LATENCY-1, go to WRITE_WAIT. Write has priority when both enables are high (write-back precedes refill).
  - else read_en_mem=1: latch addr, load counter=READ_LATENCY-1, go to READ_WAIT.
- READ_WAIT: decrement each cycle. At counter==0 on an edge:
  - data_in_mem <= mem[latched_idx]; mem_ready <= 1; go to RELEASE.
- WRITE_WAIT: decrement each cycle. At counter==0 on an edge:
  - mem[latched_idx] <= latched_data; mem_ready <= 1; go to RELEASE.
- Latency: request accepted at edge E0; mem_ready is high for exactly the cycle after edge E0+LATENCY.
- RELEASE: mem_ready <= 0. Stay until read_en_mem=0 and write_en_mem=0 are both seen, then go to IDLE. This prevents re-triggering on enables that are held past completion. No new request is accepted earlier.
- data_in_mem holds its last refill value between reads. A write does not change data_in_mem.
- Enables dropping during READ_WAIT/WRITE_WAIT do not abort the transaction (committed once accepted).
- Read-after-write to the same address returns the written data. The write commits at completion, before any later request can be accepted.
- Reset mid-transaction: the in-flight write is discarded (array untouched) and the FSM returns to IDLE.
- Counter width = $clog2(max(READ_LATENCY, WRITE_LATENCY))+1.

Decomposition:
- cache_pkg holds:
  - WORD_SIZE / WORDS_PER_BLOCK / BLOCK_SIZE defaults
  - the derived OFFSET_WIDTH
  - the state enum typedef mem_state_t {IDLE, READ_WAIT, WRITE_WAIT, RELEASE}
- One sub-module, mem_block_array:
  - single-port, synchronous-write, registered-read block storage
  - parameters MEM_BLOCKS and BLOCK_SIZE
  - exposes hierarchical array mem[] for bench preload
- The FSM and counter stay in the top.

Test Plan:
- Preload mem[5]=128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321; read_en_mem=1, blk_addr=5 held → mem_ready pulses exactly 4 cycles after acceptance with that data. busy=1 from acceptance through RELEASE. No second pulse while the enable is held.
- write_en_mem=1, blk_addr=0x1ABCDE0, dirty_block_out=128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333 → mem_ready after 3 cycles. A following read of the same address returns that block. data_in_mem is unchanged by the write.
- read_en_mem and write_en_mem both asserted in IDLE, blk_addr=7 → the write completes first (mem_ready at +3). After both enables drop and re-raise with read only, the read returns the written block.
- Request with enables dropped one cycle after acceptance → the transaction still completes and mem_ready still pulses at the nominal cycle.
- rst_n pulsed low during WRITE_WAIT to addr 9 (prior contents 128'h1111…) → outputs reset immediately. A later read of addr 9 returns 128'h1111….
- READ_LATENCY=1 build → mem_ready on the cycle right after the acceptance edge. Back-to-back requests are separated by at least one idle-enable cycle.
